// File: rtl/player_dir_ctrl.sv
// Two-player button front end: sync, debounce, queue and frame-aligned apply.
// Optional 180-degree reversal rejection: define REVERSE_GUARD_EN.
module player_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       dflt,
    input  logic       en_cond,
    input  logic [3:0] p1_btn,
    input  logic [3:0] p2_btn,
    output logic [3:0] p1_info,
    output logic [3:0] p2_info,
    output logic       p1_moving,
    output logic       p2_moving
);

    typedef enum logic {
        STOPPED = 1'b0,
        MOVING  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [7:0] raw;
    logic [7:0] sync1;
    logic [7:0] sync2;
    logic [7:0] stable;
    logic [7:0] stable_d;
    logic [7:0] rise;

    logic [3:0] info_w   [2];
    logic       moving_w [2];

    assign raw = {p2_btn, p1_btn};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable_d <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
        end
    end

    assign rise = stable & ~stable_d;

    for (genvar b = 0; b < 8; b++) begin : g_db
        logic [CNT_W-1:0] cnt;
        logic             stb;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= '0;
                stb <= 1'b0;
            end else if (sync2[b] != stb) begin
                if (cnt == CNT_LAST) begin
                    stb <= sync2[b];
                    cnt <= '0;
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end

        assign stable[b] = stb;
    end

    for (genvar p = 0; p < 2; p++) begin : g_pl
        logic [3:0] press;
        logic [3:0] press_dir;
        logic       press_any;
        logic [3:0] pend_dir;
        logic       pend_vld;
        logic [3:0] info_q;
        logic       moving_q;
        logic [3:0] opp;
        logic       reject;
        state_t     state;

        assign press     = rise[4*p +: 4];
        assign press_any = |press;

        // Simultaneous presses: lowest bit index wins.
        always_comb begin
            press_dir = 4'b0000;
            priority case (1'b1)
                press[0]: press_dir = 4'b0001;
                press[1]: press_dir = 4'b0010;
                press[2]: press_dir = 4'b0100;
                press[3]: press_dir = 4'b1000;
                default:  press_dir = 4'b0000;
            endcase
        end

        assign opp = {info_q[2], info_q[3], info_q[0], info_q[1]};

`ifdef REVERSE_GUARD_EN
        assign reject = (pend_dir == opp);
`else
        assign reject = 1'b0;
`endif

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                state    <= STOPPED;
                info_q   <= 4'b0000;
                moving_q <= 1'b0;
                pend_dir <= 4'b0000;
                pend_vld <= 1'b0;
            end else if (dflt) begin
                state    <= STOPPED;
                info_q   <= 4'b0000;
                moving_q <= 1'b0;
                pend_vld <= 1'b0;
            end else begin
                if (en_cond && pend_vld) begin
                    unique case (state)
                        STOPPED: begin
                            info_q   <= pend_dir;
                            state    <= MOVING;
                            moving_q <= 1'b1;
                        end
                        MOVING: begin
                            if (!reject)
                                info_q <= pend_dir;
                        end
                        default: begin
                            state    <= STOPPED;
                            moving_q <= 1'b0;
                        end
                    endcase
                end
                // A press alongside en_cond becomes pending for the next frame.
                if (press_any) begin
                    pend_dir <= press_dir;
                    pend_vld <= 1'b1;
                end else if (en_cond) begin
                    pend_vld <= 1'b0;
                end
            end
        end

        assign info_w[p]   = info_q;
        assign moving_w[p] = moving_q;
    end

    assign p1_info   = info_w[0];
    assign p2_info   = info_w[1];
    assign p1_moving = moving_w[0];
    assign p2_moving = moving_w[1];

endmodule

// File: tb/tb_player_dir_ctrl.sv
// Directed bench for player_dir_ctrl with DEBOUNCE_CYCLES=4.
module tb_player_dir_ctrl;

    logic       clock;
    logic       reset_n;
    logic       dflt;
    logic       en_cond;
    logic [3:0] p1_btn;
    logic [3:0] p2_btn;
    logic [3:0] p1_info;
    logic [3:0] p2_info;
    logic       p1_moving;
    logic       p2_moving;

    int total;
    int bad;

    player_dir_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .dflt      (dflt),
        .en_cond   (en_cond),
        .p1_btn    (p1_btn),
        .p2_btn    (p2_btn),
        .p1_info   (p1_info),
        .p2_info   (p2_info),
        .p1_moving (p1_moving),
        .p2_moving (p2_moving)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic frame();
        en_cond = 1'b1;
        tick(1);
        en_cond = 1'b0;
    endtask

    task automatic press(input int pl, input logic [3:0] code);
        if (pl == 1) p1_btn = code;
        else p2_btn = code;
        tick(8);
        if (pl == 1) p1_btn = 4'b0000;
        else p2_btn = 4'b0000;
        tick(8);
    endtask

    logic [3:0] exp_rev;

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        dflt    = 1'b0;
        en_cond = 1'b0;
        p1_btn  = 4'b0000;
        p2_btn  = 4'b0000;
`ifdef REVERSE_GUARD_EN
        exp_rev = 4'b0001;
`else
        exp_rev = 4'b0010;
`endif
        tick(3);
        chk("rst_p1_info", p1_info, 4'b0000);
        chk("rst_p2_info", p2_info, 4'b0000);
        chk("rst_moving", {2'b00, p2_moving, p1_moving}, 4'b0000);
        reset_n = 1'b1;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            frame();
            tick(2);
        end
        chk("idle_p1_info", p1_info, 4'b0000);
        chk("idle_p2_info", p2_info, 4'b0000);
        chk("idle_moving", {2'b00, p2_moving, p1_moving}, 4'b0000);

        p1_btn = 4'b0001;
        tick(10);
        chk("midframe_hold", p1_info, 4'b0000);
        p1_btn = 4'b0000;
        tick(8);
        chk("before_frame", p1_info, 4'b0000);
        frame();
        chk("left_p1_info", p1_info, 4'b0001);
        chk("left_p1_moving", {3'b000, p1_moving}, 4'b0001);
        chk("left_p2_info", p2_info, 4'b0000);
        chk("left_p2_moving", {3'b000, p2_moving}, 4'b0000);

        for (int i = 0; i < 10; i++) begin
            p1_btn = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            tick(2);
        end
        p1_btn = 4'b0000;
        tick(8);
        frame();
        chk("bounce_reject", p1_info, 4'b0001);

        press(1, 4'b0010);
        frame();
        chk("reverse", p1_info, exp_rev);
        chk("reverse_moving", {3'b000, p1_moving}, 4'b0001);

        press(2, 4'b0100);
        press(2, 4'b1000);
        frame();
        chk("last_wins_p2", p2_info, 4'b1000);
        chk("last_wins_p1", p1_info, exp_rev);

        press(1, 4'b0100);
        dflt    = 1'b1;
        en_cond = 1'b1;
        tick(1);
        dflt    = 1'b0;
        en_cond = 1'b0;
        chk("dflt_p1_info", p1_info, 4'b0000);
        chk("dflt_p2_info", p2_info, 4'b0000);
        chk("dflt_moving", {2'b00, p2_moving, p1_moving}, 4'b0000);
        tick(2);
        frame();
        chk("dflt_pend_clr", p1_info, 4'b0000);
        chk("dflt_still_stop", {3'b000, p1_moving}, 4'b0000);

        press(2, 4'b1010);
        frame();
        chk("lowest_bit_p2", p2_info, 4'b0010);
        chk("lowest_bit_p1", p1_info, 4'b0000);

        p1_btn = 4'b0001;
        tick(4);
        reset_n = 1'b0;
        p1_btn  = 4'b0000;
        tick(1);
        reset_n = 1'b1;
        tick(10);
        frame();
        chk("rst_mid_db_info", p1_info, 4'b0000);
        chk("rst_mid_db_mov", {3'b000, p1_moving}, 4'b0000);
        chk("rst_p2_cleared", p2_info, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
